// File: rtl/cache_control_vb.sv
// cache_control_vb: N-way set-associative write-back cache controller with
// tree pseudo-LRU replacement and a one-entry victim buffer. Dirty victims
// are parked in the buffer so the new line is fetched first; the buffered
// line drains to memory while CPU hits continue to be served.
module cache_control_vb #(
  parameter int NUM_WAYS = 4,
  parameter int WAY_W    = $clog2(NUM_WAYS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_read,
  input  logic                mem_write,
  output logic                mem_resp,
  input  logic [NUM_WAYS-1:0] hit_bits,
  input  logic [NUM_WAYS-1:0] valid_bits,
  input  logic [NUM_WAYS-1:0] dirty_bits,
  input  logic [NUM_WAYS-2:0] plru_bits,
  output logic [NUM_WAYS-2:0] plru_next,
  output logic                load_plru,
  output logic [WAY_W-1:0]    hit_way,
  output logic [WAY_W-1:0]    victim_way,
  output logic [NUM_WAYS-1:0] tag_load,
  output logic [NUM_WAYS-1:0] data_we,
  output logic                data_fill,
  output logic [NUM_WAYS-1:0] load_valid,
  output logic [NUM_WAYS-1:0] load_dirty,
  output logic                dirty_in,
  output logic                vbuf_load,
  output logic                vbuf_valid,
  output logic                pmem_read,
  output logic                pmem_write,
  output logic                pmem_addr_sel,
  input  logic                pmem_resp
);

  localparam logic [1:0] CHECK      = 2'd0;
  localparam logic [1:0] CAPTURE    = 2'd1;
  localparam logic [1:0] FILL       = 2'd2;
  localparam logic [1:0] WAIT_DRAIN = 2'd3;

  // Tree node numbering: leaves sit at nodes NUM_WAYS-1 .. 2*NUM_WAYS-2.
  localparam logic [WAY_W:0] LEAF_BASE = (WAY_W+1)'(NUM_WAYS - 1);

  logic [1:0]          state_q, state_d;
  logic                vbuf_valid_q, vbuf_valid_d;
  logic                req, hit, draining;
  logic [NUM_WAYS-1:0] hit_oh, victim_oh;
  logic [NUM_WAYS-2:0] plru_touch;
  logic [WAY_W:0]      vnode, vleaf;
  logic [WAY_W:0]      tnode, tparent;

  assign req        = mem_read | mem_write;
  assign hit        = |hit_bits;
  assign vbuf_valid = vbuf_valid_q;
  assign hit_oh     = NUM_WAYS'(1) << hit_way;
  assign victim_oh  = NUM_WAYS'(1) << victim_way;

  // Priority encode the lowest hitting way.
  always_comb begin
    hit_way = '0;
    for (int unsigned i = NUM_WAYS; i > 0; i--) begin
      if (hit_bits[i-1]) hit_way = WAY_W'(i - 1);
    end
  end

  // Walk the PLRU tree from the root: bit 0 goes left, bit 1 goes right.
  always_comb begin
    vnode = '0;
    for (int unsigned lvl = 0; lvl < WAY_W; lvl++) begin
      vnode = {vnode[WAY_W-1:0], 1'b1}
            + {{WAY_W{1'b0}}, plru_bits[vnode[WAY_W-1:0]]};
    end
    vleaf      = vnode - LEAF_BASE;
    victim_way = vleaf[WAY_W-1:0];
  end

  // Touch hit_way: climb from its leaf, pointing each ancestor away from it.
  always_comb begin
    plru_touch = plru_bits;
    tnode      = LEAF_BASE + {1'b0, hit_way};
    tparent    = '0;
    for (int unsigned lvl = 0; lvl < WAY_W; lvl++) begin
      tparent = (tnode - 1'b1) >> 1;
      // Odd node numbers are left children.
      plru_touch[tparent[WAY_W-1:0]] = tnode[0];
      tnode = tparent;
    end
  end

  // The buffered line drains whenever the controller is not using memory.
  assign draining = vbuf_valid_q && (state_q == CHECK || state_q == WAIT_DRAIN);

  // Next-state and output decode.
  always_comb begin
    state_d       = state_q;
    mem_resp      = 1'b0;
    plru_next     = plru_bits;
    load_plru     = 1'b0;
    tag_load      = '0;
    data_we       = '0;
    data_fill     = 1'b0;
    load_valid    = '0;
    load_dirty    = '0;
    dirty_in      = 1'b0;
    vbuf_load     = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = draining;
    pmem_addr_sel = draining;
    case (state_q)
      CHECK: begin
        if (req && hit) begin
          mem_resp  = 1'b1;
          load_plru = 1'b1;
          plru_next = plru_touch;
          if (mem_write) begin
            data_we    = hit_oh;
            load_dirty = hit_oh;
            dirty_in   = 1'b1;
          end
        end else if (req) begin
          if (vbuf_valid_q)
            state_d = WAIT_DRAIN;
          else if (valid_bits[victim_way] && dirty_bits[victim_way])
            state_d = CAPTURE;
          else
            state_d = FILL;
        end
      end
      CAPTURE: begin
        vbuf_load  = 1'b1;
        load_dirty = victim_oh;
        state_d    = FILL;
      end
      FILL: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          tag_load   = victim_oh;
          data_we    = victim_oh;
          data_fill  = 1'b1;
          load_valid = victim_oh;
          load_dirty = victim_oh;
          state_d    = CHECK;
        end
      end
      WAIT_DRAIN: begin
        // Also leave if the drain finished in the same cycle the miss was
        // seen in CHECK; otherwise no further pmem_resp would arrive.
        if (pmem_resp || !vbuf_valid_q) state_d = CHECK;
      end
      default: state_d = CHECK;
    endcase
  end

  // Victim buffer occupancy: set on capture, cleared by the drain response.
  always_comb begin
    vbuf_valid_d = vbuf_valid_q;
    if (vbuf_load)
      vbuf_valid_d = 1'b1;
    else if (pmem_write && pmem_resp)
      vbuf_valid_d = 1'b0;
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= CHECK;
      vbuf_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      vbuf_valid_q <= vbuf_valid_d;
    end
  end

endmodule

// File: tb/tb_cache_control_vb.sv
// Directed bench for cache_control_vb with NUM_WAYS=4. Every output is
// packed into one vector per cycle and compared against a hand-derived
// expectation taken from a scoreboard queue.
module tb_cache_control_vb;

  typedef struct packed {
    logic       mem_resp;
    logic       load_plru;
    logic [2:0] plru_next;
    logic [1:0] hit_way;
    logic [1:0] victim_way;
    logic [3:0] tag_load;
    logic [3:0] data_we;
    logic       data_fill;
    logic [3:0] load_valid;
    logic [3:0] load_dirty;
    logic       dirty_in;
    logic       vbuf_load;
    logic       vbuf_valid;
    logic       pmem_read;
    logic       pmem_write;
    logic       pmem_addr_sel;
  } out_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rd = 1'b0, wr = 1'b0, presp = 1'b0;
  logic [3:0] hb = '0, vb = '0, db = '0;
  logic [2:0] pb = '0;

  logic       mem_resp, load_plru, data_fill, dirty_in, vbuf_load, vbuf_valid;
  logic       pmem_read, pmem_write, pmem_addr_sel;
  logic [2:0] plru_next;
  logic [1:0] hit_way, victim_way;
  logic [3:0] tag_load, data_we, load_valid, load_dirty;

  out_t  obs, e, exp_v;
  out_t  exp_q[$];
  string tag_q[$];
  string tag;
  int    vectors = 0;
  int    miscompares = 0;

  always #5 clk = ~clk;

  cache_control_vb #(.NUM_WAYS(4)) dut (
    .clk(clk), .rst(rst), .mem_read(rd), .mem_write(wr), .mem_resp(mem_resp),
    .hit_bits(hb), .valid_bits(vb), .dirty_bits(db), .plru_bits(pb),
    .plru_next(plru_next), .load_plru(load_plru), .hit_way(hit_way),
    .victim_way(victim_way), .tag_load(tag_load), .data_we(data_we),
    .data_fill(data_fill), .load_valid(load_valid), .load_dirty(load_dirty),
    .dirty_in(dirty_in), .vbuf_load(vbuf_load), .vbuf_valid(vbuf_valid),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_addr_sel(pmem_addr_sel), .pmem_resp(presp)
  );

  always_comb
    obs = {mem_resp, load_plru, plru_next, hit_way, victim_way, tag_load,
           data_we, data_fill, load_valid, load_dirty, dirty_in, vbuf_load,
           vbuf_valid, pmem_read, pmem_write, pmem_addr_sel};

  task automatic base(input logic [2:0] pn, input logic [1:0] hw,
                      input logic [1:0] vw, input logic vv);
    e            = '0;
    e.plru_next  = pn;
    e.hit_way    = hw;
    e.victim_way = vw;
    e.vbuf_valid = vv;
  endtask

  task automatic hit_exp();
    e.mem_resp  = 1'b1;
    e.load_plru = 1'b1;
  endtask

  task automatic wr_exp(input logic [3:0] oh);
    e.data_we    = oh;
    e.load_dirty = oh;
    e.dirty_in   = 1'b1;
  endtask

  task automatic fill_exp(input logic [3:0] oh);
    e.pmem_read  = 1'b1;
    e.tag_load   = oh;
    e.data_we    = oh;
    e.data_fill  = 1'b1;
    e.load_valid = oh;
    e.load_dirty = oh;
  endtask

  task automatic drain_exp();
    e.pmem_write    = 1'b1;
    e.pmem_addr_sel = 1'b1;
  endtask

  // Push the expectation, compare mid-cycle, then advance past the edge.
  task automatic step(input string t);
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(negedge clk);
    exp_v = exp_q.pop_front();
    tag   = tag_q.pop_front();
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk); #1;
    rst = 1'b0;
    base(3'b000, 2'd0, 2'd0, 1'b0);                    step("reset_idle");

    // Hits
    rd = 1'b1; hb = 4'b0100;
    base(3'b100, 2'd2, 2'd0, 1'b0); hit_exp();         step("rd_hit_w2");
    hb = 4'b1010;
    base(3'b001, 2'd1, 2'd0, 1'b0); hit_exp();         step("multi_hit");
    pb = 3'b111; hb = 4'b1000;
    base(3'b010, 2'd3, 2'd3, 1'b0); hit_exp();         step("rd_hit_w3");
    rd = 1'b0; wr = 1'b1; pb = 3'b000; hb = 4'b0010;
    base(3'b001, 2'd1, 2'd0, 1'b0); hit_exp(); wr_exp(4'b0010);
    step("wr_hit_w1");

    // Clean miss, memory answers on the fifth FILL cycle
    wr = 1'b0; rd = 1'b1; hb = '0; vb = '0; db = '0;
    base(3'b000, 2'd0, 2'd0, 1'b0);                    step("cmiss_check");
    for (int i = 0; i < 5; i++) begin
      presp = (i == 4);
      base(3'b000, 2'd0, 2'd0, 1'b0); e.pmem_read = 1'b1;
      if (i == 4) fill_exp(4'b0001);
      step("cmiss_fill");
    end
    presp = 1'b0; hb = 4'b0001; vb = 4'b0001;
    base(3'b011, 2'd0, 2'd0, 1'b0); hit_exp();         step("cmiss_hit");

    // Dirty miss on way 2 followed by drain
    hb = '0; vb = 4'b1111; db = 4'b0100; pb = 3'b011;
    base(3'b011, 2'd0, 2'd2, 1'b0);                    step("dmiss_check");
    base(3'b011, 2'd0, 2'd2, 1'b0);
    e.vbuf_load = 1'b1; e.load_dirty = 4'b0100;        step("dmiss_capture");
    base(3'b011, 2'd0, 2'd2, 1'b1); e.pmem_read = 1'b1; step("dmiss_fill_wait");
    presp = 1'b1;
    base(3'b011, 2'd0, 2'd2, 1'b1); fill_exp(4'b0100); step("dmiss_fill_resp");
    presp = 1'b0; hb = 4'b0100;
    base(3'b110, 2'd2, 2'd2, 1'b1); hit_exp(); drain_exp(); step("dmiss_hit");
    rd = 1'b0; hb = '0;
    base(3'b011, 2'd0, 2'd2, 1'b1); drain_exp();       step("drain_idle");
    wr = 1'b1; hb = 4'b0010;
    base(3'b001, 2'd1, 2'd2, 1'b1); hit_exp(); wr_exp(4'b0010); drain_exp();
    step("drain_wr_hit");

    // Miss while the buffer is still draining
    wr = 1'b0; rd = 1'b1; hb = '0; db = '0;
    base(3'b011, 2'd0, 2'd2, 1'b1); drain_exp();       step("drain_miss");
    base(3'b011, 2'd0, 2'd2, 1'b1); drain_exp();       step("wait_drain");
    presp = 1'b1;
    base(3'b011, 2'd0, 2'd2, 1'b1); drain_exp();       step("wait_drain_resp");
    presp = 1'b0;
    base(3'b011, 2'd0, 2'd2, 1'b0);                    step("post_drain_check");
    presp = 1'b1;
    base(3'b011, 2'd0, 2'd2, 1'b0); fill_exp(4'b0100); step("redo_fill");
    presp = 1'b0; hb = 4'b0100;
    base(3'b110, 2'd2, 2'd2, 1'b0); hit_exp();         step("redo_hit");

    // Reset in the middle of a drain
    hb = '0; db = 4'b0100;
    base(3'b011, 2'd0, 2'd2, 1'b0);                    step("r_check");
    base(3'b011, 2'd0, 2'd2, 1'b0);
    e.vbuf_load = 1'b1; e.load_dirty = 4'b0100;        step("r_capture");
    presp = 1'b1;
    base(3'b011, 2'd0, 2'd2, 1'b1); fill_exp(4'b0100); step("r_fill");
    presp = 1'b0; hb = 4'b0100;
    base(3'b110, 2'd2, 2'd2, 1'b1); hit_exp(); drain_exp(); step("r_hit");
    rd = 1'b0; hb = '0;
    base(3'b011, 2'd0, 2'd2, 1'b1); drain_exp();       step("r_drain");
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; rd = 1'b1; db = '0;
    base(3'b011, 2'd0, 2'd2, 1'b0);                    step("rst_post");
    presp = 1'b1;
    base(3'b011, 2'd0, 2'd2, 1'b0); fill_exp(4'b0100); step("rst_fill");
    presp = 1'b0; hb = 4'b0100;
    base(3'b110, 2'd2, 2'd2, 1'b0); hit_exp();         step("rst_hit");
    rd = 1'b0; hb = '0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
